hci_core_split_buffered: RTL

//  Splits one wide HCI-core TCDM request (DW bits) into NB_OUT_CHAN narrow requests, one per output channel,

---
 rtl/hci_core_split_buffered_pkg.sv | 11 +
 rtl/hci_core_split_buffered_if.sv | 32 +++
 rtl/hci_core_split_buffered_rfifo.sv | 71 +++++++
 rtl/hci_core_split_buffered.sv | 106 ++++++++++
 4 files changed

// File: rtl/hci_core_split_buffered_pkg.sv
// Shared definitions for the buffered wide-to-narrow HCI-core request splitter.
package hci_core_split_buffered_pkg;

    localparam int unsigned BOFFS_W = 4;

    // Counter width able to hold 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/hci_core_split_buffered_if.sv
// HCI-core request/response bundle; master drives the request and lrdy, slave answers.
interface hci_core_split_buffered_if #(
    parameter int unsigned DW = 128,
    parameter int unsigned AW = 32
) ();
    import hci_core_split_buffered_pkg::*;

    localparam int unsigned BW = DW / 8;

    logic               req;
    logic               gnt;
    logic [AW-1:0]      add;
    logic               wen;
    logic [DW-1:0]      data;
    logic [BW-1:0]      be;
    logic [BOFFS_W-1:0] boffs;
    logic               lrdy;
    logic [DW-1:0]      r_data;
    logic               r_valid;
    logic               r_opc;

    modport master (
        output req, add, wen, data, be, boffs, lrdy,
        input  gnt, r_data, r_valid, r_opc
    );

    modport slave (
        input  req, add, wen, data, be, boffs, lrdy,
        output gnt, r_data, r_valid, r_opc
    );

endinterface

// File: rtl/hci_core_split_buffered_rfifo.sv
// Per-channel response FIFO: registered head (no fall-through), push and pop in the same
// cycle allowed even when full; a push into a full FIFO without a pop is dropped.
module hci_core_split_buffered_rfifo
    import hci_core_split_buffered_pkg::*;
#(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] dat_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned      CNT_W    = cnt_width(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= dat_i;
    end

    // A dropped push means the upstream credit accounting was violated.
    always_ff @(posedge clk_i) begin
        if (!rst_i && !clear_i) assert (!(push_i && !do_push));
    end

endmodule

// File: rtl/hci_core_split_buffered.sv
// Splits a wide HCI-core request across NB_OUT_CHAN narrow channels with up to FIFO_DEPTH outstanding;
// responses re-joined 1 cycle after the last channel answers; stalls requests when credits run out, honours lrdy.
module hci_core_split_buffered
    import hci_core_split_buffered_pkg::*;
#(
    parameter int unsigned DW          = 128,
    parameter int unsigned AW          = 32,
    parameter int unsigned NB_OUT_CHAN = 4,
    parameter int unsigned FIFO_DEPTH  = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        clear_i,
    hci_core_split_buffered_if.slave    tcdm_slave,
    hci_core_split_buffered_if.master   tcdm_master [NB_OUT_CHAN-1:0]
);

    localparam int unsigned DW_OUT = DW / NB_OUT_CHAN;
    localparam int unsigned BW_OUT = DW_OUT / 8;
    localparam int unsigned CNT_W  = cnt_width(FIFO_DEPTH);

    if ((DW % NB_OUT_CHAN) != 0 || (DW_OUT % 8) != 0 || NB_OUT_CHAN < 2 || FIFO_DEPTH < 1) begin : g_param_check
        $error("hci_core_split_buffered: illegal DW/NB_OUT_CHAN/FIFO_DEPTH combination");
    end

    typedef struct packed {
        logic [DW_OUT-1:0] r_data;
        logic              r_opc;
    } resp_t;

    logic [NB_OUT_CHAN-1:0] gnt_mask_q, gnt_mask_d;
    logic [NB_OUT_CHAN-1:0] master_req, master_gnt;
    logic [NB_OUT_CHAN-1:0] rsp_push, fifo_full, fifo_empty;
    resp_t                  rsp_head [NB_OUT_CHAN];
    logic [DW-1:0]          r_data_join;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   soft_rst, stall, slave_gnt, rsp_valid, rsp_pop, r_opc_any;
    logic                   unused_ok;

    assign soft_rst   = rst_i | clear_i;
    assign stall      = (cnt_q == CNT_W'(FIFO_DEPTH));
    // Channels already granted for the current wide request are masked off until the wide grant.
    assign master_req = {NB_OUT_CHAN{tcdm_slave.req & ~stall & ~soft_rst}} & ~gnt_mask_q;
    assign slave_gnt  = tcdm_slave.req & ~stall & ~soft_rst & (&(master_gnt | gnt_mask_q));
    assign rsp_valid  = ~|fifo_empty;
    assign rsp_pop    = rsp_valid & tcdm_slave.lrdy;

    always_comb begin
        gnt_mask_d = slave_gnt ? '0 : (gnt_mask_q | (master_req & master_gnt));
        cnt_d      = cnt_q;
        if (slave_gnt && !rsp_pop)      cnt_d = cnt_q + 1'b1;
        else if (rsp_pop && !slave_gnt) cnt_d = cnt_q - 1'b1;
    end

    always_comb begin
        r_opc_any = 1'b0;
        for (int i = 0; i < NB_OUT_CHAN; i++) r_opc_any = r_opc_any | rsp_head[i].r_opc;
    end

    always_ff @(posedge clk_i) begin
        if (soft_rst) begin
            gnt_mask_q <= '0;
            cnt_q      <= '0;
        end else begin
            gnt_mask_q <= gnt_mask_d;
            cnt_q      <= cnt_d;
        end
    end

    for (genvar g = 0; g < NB_OUT_CHAN; g++) begin : g_ch
        assign tcdm_master[g].req   = master_req[g];
        assign tcdm_master[g].add   = tcdm_slave.add + AW'(g * BW_OUT);
        assign tcdm_master[g].wen   = tcdm_slave.wen;
        assign tcdm_master[g].data  = tcdm_slave.data[g*DW_OUT +: DW_OUT];
        assign tcdm_master[g].be    = tcdm_slave.be[g*BW_OUT +: BW_OUT];
        assign tcdm_master[g].boffs = '0;
        assign tcdm_master[g].lrdy  = 1'b1;
        assign master_gnt[g]        = tcdm_master[g].gnt;
        assign rsp_push[g]          = tcdm_master[g].r_valid;

        hci_core_split_buffered_rfifo #(
            .WIDTH ($bits(resp_t)),
            .DEPTH (FIFO_DEPTH)
        ) i_rfifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .clear_i (clear_i),
            .push_i  (rsp_push[g]),
            .dat_i   ({tcdm_master[g].r_data, tcdm_master[g].r_opc}),
            .pop_i   (rsp_pop),
            .full_o  (fifo_full[g]),
            .empty_o (fifo_empty[g]),
            .head_o  (rsp_head[g])
        );

        assign r_data_join[g*DW_OUT +: DW_OUT] = rsp_head[g].r_data;
    end

    assign tcdm_slave.gnt     = slave_gnt;
    assign tcdm_slave.r_valid = rsp_valid;
    assign tcdm_slave.r_data  = r_data_join;
    assign tcdm_slave.r_opc   = r_opc_any;

    assign unused_ok = ^{tcdm_slave.boffs, fifo_full};

endmodule
